// File: rtl/quad_step_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : quad_step_decoder
//  Description : Synchronises and glitch-filters a two-phase quadrature input,
//                then emits one-clock step pulses with a direction flag and a
//                sticky error on illegal (double-bit) transitions.
//  Revision    : 1.0  initial release
// ============================================================================
module quad_step_decoder #(
    parameter int FILT_CYCLES = 4,
    parameter int FILT_W      = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic a_in,
    input  logic b_in,
    input  logic err_clr,
    output logic step,
    output logic dir,
    output logic err
);

    localparam logic [FILT_W-1:0] c_filt_done = FILT_W'(FILT_CYCLES);
    localparam logic [FILT_W-1:0] c_cnt_one   = FILT_W'(1);

    // Bit 1 carries phase A, bit 0 carries phase B throughout.
    logic [1:0] r_meta;
    logic [1:0] r_sync;
    logic [1:0] w_filt;
    logic [1:0] r_state;
    logic [1:0] r_prev;
    logic       r_step;
    logic       r_dir;
    logic       r_err;
    logic       w_fwd;
    logic       w_rev;
    logic       w_ill;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 2'b00;
            r_sync <= 2'b00;
        end else begin
            r_meta <= {a_in, b_in};
            r_sync <= r_meta;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_filt
        logic [FILT_W-1:0] r_cnt;
        logic [FILT_W-1:0] w_cnt_inc;
        logic              r_flt;

        assign w_cnt_inc  = r_cnt + c_cnt_one;
        assign w_filt[gi] = r_flt;

        // The counter is cleared on acceptance, so it tops out at FILT_CYCLES-1.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_cnt <= '0;
                r_flt <= 1'b0;
            end else if (r_sync[gi] == r_flt) begin
                r_cnt <= '0;
            end else if (w_cnt_inc == c_filt_done) begin
                r_flt <= r_sync[gi];
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    // Forward order 00->01->11->10->00; reverse is the mirror sequence.
    assign w_fwd = (r_state == {r_prev[0], ~r_prev[1]});
    assign w_rev = (r_state == {~r_prev[0], r_prev[1]});
    assign w_ill = ((r_state ^ r_prev) == 2'b11);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= 2'b00;
            r_prev  <= 2'b00;
            r_step  <= 1'b0;
            r_dir   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_filt;
            r_prev  <= r_state;
            r_step  <= w_fwd | w_rev;
            if (w_fwd) begin
                r_dir <= 1'b1;
            end else if (w_rev) begin
                r_dir <= 1'b0;
            end
            if (w_ill) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign step = r_step;
    assign dir  = r_dir;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_quad_step_decoder
//  Description : Scoreboard bench for quad_step_decoder: expected step
//                directions are queued as phases are driven and matched as
//                step pulses appear.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_quad_step_decoder;

    localparam int c_fc = 4;

    logic clk = 1'b0;
    logic reset;
    logic a_in;
    logic b_in;
    logic err_clr;
    logic step;
    logic dir;
    logic err;

    int   n_checks   = 0;
    int   n_pass     = 0;
    int   cnt        = 0;
    int   steps_seen = 0;
    logic exp_dir;
    logic sb_q[$];

    always #5 clk = ~clk;

    quad_step_decoder #(
        .FILT_CYCLES(c_fc),
        .FILT_W     (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .a_in   (a_in),
        .b_in   (b_in),
        .err_clr(err_clr),
        .step   (step),
        .dir    (dir),
        .err    (err)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Downstream up/down counter model plus scoreboard pop on each step.
    always @(negedge clk) begin
        if (step === 1'b1) begin
            steps_seen++;
            if (dir) cnt++;
            else cnt--;
            if (sb_q.size() == 0) begin
                check_eq("unexpected_step", 1, 0);
            end else begin
                exp_dir = sb_q.pop_front();
                check_eq("step_dir", int'(dir), int'(exp_dir));
            end
        end
    end

    task automatic move(input logic a, input logic b, input bit push, input logic d);
        a_in = a;
        b_in = b;
        if (push) sb_q.push_back(d);
        repeat (10) @(negedge clk);
    endtask

    task automatic clear_err(input string tag);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq(tag, int'(err), 0);
    endtask

    initial begin
        reset   = 1'b0;
        a_in    = 1'b0;
        b_in    = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_step", int'(step), 0);
        check_eq("rst_dir", int'(dir), 0);
        check_eq("rst_err", int'(err), 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Forward cycle
        move(1'b0, 1'b1, 1'b1, 1'b1);
        move(1'b1, 1'b1, 1'b1, 1'b1);
        move(1'b1, 1'b0, 1'b1, 1'b1);
        move(1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("fwd_queue", sb_q.size(), 0);
        check_eq("fwd_count", cnt, 4);
        check_eq("fwd_steps", steps_seen, 4);
        check_eq("fwd_err", int'(err), 0);

        // Reverse cycle
        move(1'b1, 1'b0, 1'b1, 1'b0);
        move(1'b1, 1'b1, 1'b1, 1'b0);
        move(1'b0, 1'b1, 1'b1, 1'b0);
        move(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("rev_queue", sb_q.size(), 0);
        check_eq("rev_count", cnt, 0);
        check_eq("rev_steps", steps_seen, 8);
        check_eq("rev_dir", int'(dir), 0);

        // Glitch filter: 3-clock pulse rejected, 4-clock pulse accepted
        a_in = 1'b1;
        repeat (3) @(negedge clk);
        a_in = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("glitch3_steps", steps_seen, 8);
        a_in = 1'b1;
        sb_q.push_back(1'b0);
        repeat (4) @(negedge clk);
        a_in = 1'b0;
        sb_q.push_back(1'b1);
        repeat (12) @(negedge clk);
        check_eq("pulse4_steps", steps_seen, 10);
        check_eq("pulse4_queue", sb_q.size(), 0);

        // Illegal double-bit jumps
        move(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("ill_err_set", int'(err), 1);
        check_eq("ill_no_step", steps_seen, 10);
        clear_err("ill_err_clr");
        move(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("ill_back_err", int'(err), 1);
        clear_err("ill_back_clr");
        check_eq("ill_steps", steps_seen, 10);

        // Latency: input changes just before edge 0, step after edge 7 only
        move(1'b0, 1'b1, 1'b1, 1'b1);
        a_in = 1'b1;
        sb_q.push_back(1'b1);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check_eq($sformatf("lat_edge%0d", i), int'(step), int'(i == 7));
        end
        repeat (3) @(negedge clk);
        check_eq("lat_dir", int'(dir), 1);

        // err set wins over a simultaneous err_clr
        err_clr = 1'b1;
        a_in    = 1'b0;
        b_in    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq($sformatf("prio_edge%0d", i), int'(err), int'(i == 7));
        end
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("prio_hold", int'(err), 1);
        clear_err("prio_clr");
        check_eq("lat_queue", sb_q.size(), 0);
        check_eq("lat_count", cnt, 2);

        // Reset in the middle of a filter count
        a_in = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("midrst_step", int'(step), 0);
        check_eq("midrst_dir", int'(dir), 0);
        check_eq("midrst_err", int'(err), 0);
        a_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        check_eq("midrst_no_step", steps_seen, 12);
        move(1'b0, 1'b1, 1'b1, 1'b1);
        move(1'b1, 1'b1, 1'b1, 1'b1);
        move(1'b1, 1'b0, 1'b1, 1'b1);
        move(1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("post_rst_count", cnt, 6);
        check_eq("post_rst_steps", steps_seen, 16);
        check_eq("post_rst_queue", sb_q.size(), 0);
        check_eq("post_rst_err", int'(err), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
